spi_txn_arbiter: RTL and testbench

- Shares one SPI master engine between `NUM_CLIENTS` requesters using round-robin arbitration.
- For each transaction it latches the winner's mode and TX word, drives that client's chip select, and starts the engine.
- It waits for the engine to finish, then returns the RX word (or a timeout error) to the owning client.
- It sits between the client logic and the SPI master/slave datapath, in the `clk` domain.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/spi_txn_arbiter.sv | 144 ++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI transaction arbiter: SPI mode encoding and arbiter FSM states.
package spi_pkg;

  typedef logic [1:0] spi_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    WAIT,
    GAP
  } arb_state_t;

  // {CPOL, CPHA}
  localparam spi_mode_t MODE0 = 2'b00;
  localparam spi_mode_t MODE1 = 2'b01;
  localparam spi_mode_t MODE2 = 2'b10;
  localparam spi_mode_t MODE3 = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requester strictly after `last`, wrapping.
module rr_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int IW          = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IW-1:0]          last,
  output logic [NUM_CLIENTS-1:0] pick,
  output logic [IW-1:0]          idx,
  output logic                   any
);

  logic [2*NUM_CLIENTS-1:0] dbl;
  logic [NUM_CLIENTS-1:0]   rot;
  logic [IW:0]              sum;
  logic                     found;

  // rot[j] is the request of client (last+1+j) mod NUM_CLIENTS
  assign dbl = {req, req} >> ({1'b0, last} + 1'b1);
  assign rot = dbl[NUM_CLIENTS-1:0];
  assign any = |req;

  always_comb begin
    found = 1'b0;
    sum   = '0;
    for (int j = 0; j < NUM_CLIENTS; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        sum   = {1'b0, last} + (IW+1)'(j) + 1'b1;
      end
    end
    if (sum >= (IW+1)'(NUM_CLIENTS))
      sum = sum - (IW+1)'(NUM_CLIENTS);
    idx  = sum[IW-1:0];
    pick = any ? (NUM_CLIENTS'(1) << idx) : '0;
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin sharing of one SPI master engine between NUM_CLIENTS requesters,
// with per-client chip select, CS gap between transactions and a WAIT timeout.
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int CS_GAP      = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CLIENTS-1:0]          req,
  input  logic [2*NUM_CLIENTS-1:0]        req_mode,
  input  logic [DATA_WIDTH*NUM_CLIENTS-1:0] req_data,
  output logic [NUM_CLIENTS-1:0]          gnt,
  output logic [NUM_CLIENTS-1:0]          rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            rsp_err,
  output logic                            m_start,
  output spi_mode_t                       m_mode,
  output logic [DATA_WIDTH-1:0]           m_tx_data,
  input  logic                            m_done,
  input  logic [DATA_WIDTH-1:0]           m_rx_data,
  output logic [NUM_CLIENTS-1:0]          cs_n
);

  localparam int IW      = $clog2(NUM_CLIENTS);
  localparam int GAP_CYC = (CS_GAP > 0) ? CS_GAP : 1;
  localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t state, state_nxt;
  logic [IW-1:0]          last, last_nxt, pick_idx;
  logic [NUM_CLIENTS-1:0] own, own_nxt, pick;
  logic                   req_any;
  logic [TW-1:0]          tcnt, tcnt_nxt;
  logic [GW-1:0]          gcnt, gcnt_nxt;

  logic [NUM_CLIENTS-1:0] gnt_nxt, rsp_valid_nxt, cs_n_nxt;
  logic [DATA_WIDTH-1:0]  rsp_data_nxt, m_tx_nxt;
  logic                   rsp_err_nxt, m_start_nxt;
  spi_mode_t              m_mode_nxt;

  rr_arbiter #(.NUM_CLIENTS(NUM_CLIENTS), .IW(IW)) u_arb (
    .req  (req),
    .last (last),
    .pick (pick),
    .idx  (pick_idx),
    .any  (req_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= IW'(NUM_CLIENTS-1);
      own       <= '0;
      tcnt      <= '0;
      gcnt      <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      cs_n      <= '1;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      m_start   <= 1'b0;
      m_mode    <= MODE0;
      m_tx_data <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      own       <= own_nxt;
      tcnt      <= tcnt_nxt;
      gcnt      <= gcnt_nxt;
      gnt       <= gnt_nxt;
      rsp_valid <= rsp_valid_nxt;
      cs_n      <= cs_n_nxt;
      rsp_data  <= rsp_data_nxt;
      rsp_err   <= rsp_err_nxt;
      m_start   <= m_start_nxt;
      m_mode    <= m_mode_nxt;
      m_tx_data <= m_tx_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    own_nxt       = own;
    tcnt_nxt      = tcnt;
    gcnt_nxt      = gcnt;
    gnt_nxt       = '0;
    rsp_valid_nxt = '0;
    m_start_nxt   = 1'b0;
    cs_n_nxt      = cs_n;
    rsp_data_nxt  = rsp_data;
    rsp_err_nxt   = rsp_err;
    m_mode_nxt    = m_mode;
    m_tx_nxt      = m_tx_data;

    unique case (state)
      IDLE: begin
        if (req_any) begin
          last_nxt  = pick_idx;
          own_nxt   = pick;
          gnt_nxt   = pick;
          cs_n_nxt  = ~pick;
          state_nxt = SETUP;
          for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (pick[i]) begin
              m_mode_nxt = req_mode[2*i +: 2];
              m_tx_nxt   = req_data[DATA_WIDTH*i +: DATA_WIDTH];
            end
          end
        end
      end
      SETUP: begin
        m_start_nxt = 1'b1;
        state_nxt   = START;
      end
      START: begin
        tcnt_nxt  = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        tcnt_nxt = tcnt + 1'b1;
        // completion wins over a timeout firing in the same cycle
        if (m_done || tcnt == TW'(TIMEOUT-1)) begin
          rsp_data_nxt  = m_done ? m_rx_data : '0;
          rsp_err_nxt   = !m_done;
          rsp_valid_nxt = own;
          cs_n_nxt      = '1;
          gcnt_nxt      = '0;
          state_nxt     = GAP;
        end
      end
      GAP: begin
        if (gcnt == GW'(GAP_CYC-1)) state_nxt = IDLE;
        else                        gcnt_nxt  = gcnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Randomized bench for spi_txn_arbiter: two instances (CS_GAP=2 and CS_GAP=0) checked
// every cycle against a transaction-timeline reference model.
module tb_spi_txn_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int TO   = 16;
  localparam int NCYC = 2200;

  logic clk = 1'b0;
  logic rst;
  logic [1:0][N-1:0]    req, gnt, rsp_valid, cs_n;
  logic [1:0][2*N-1:0]  req_mode;
  logic [1:0][DW*N-1:0] req_data;
  logic [1:0][DW-1:0]   rsp_data, m_tx_data, m_rx_data;
  logic [1:0][1:0]      m_mode;
  logic [1:0]           rsp_err, m_start, m_done;

  always #5 clk = ~clk;

  spi_txn_arbiter #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .CS_GAP(2), .TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst), .req(req[0]), .req_mode(req_mode[0]), .req_data(req_data[0]),
    .gnt(gnt[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
    .m_start(m_start[0]), .m_mode(m_mode[0]), .m_tx_data(m_tx_data[0]),
    .m_done(m_done[0]), .m_rx_data(m_rx_data[0]), .cs_n(cs_n[0])
  );

  spi_txn_arbiter #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .CS_GAP(0), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .req(req[1]), .req_mode(req_mode[1]), .req_data(req_data[1]),
    .gnt(gnt[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
    .m_start(m_start[1]), .m_mode(m_mode[1]), .m_tx_data(m_tx_data[1]),
    .m_done(m_done[1]), .m_rx_data(m_rx_data[1]), .cs_n(cs_n[1])
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input int i, input int k,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc%0d got=%0h exp=%0h", tag, i, k, got, exp);
    end
  endtask

  // Reference model: one transaction timeline per instance, in absolute cycle numbers.
  int m_in[2], m_g[2], m_s[2], m_end[2], m_free[2], m_rsp[2];
  int m_own[2], m_last[2], m_mode_e[2], m_data_e[2], m_rx_e[2], m_err_e[2];

  function automatic int gap_len(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int o = 1; o <= N; o++)
      if (r[(last + o) % N]) return (last + o) % N;
    return -1;
  endfunction

  task automatic model_reset(input int i);
    m_in[i] = 0; m_last[i] = N - 1; m_mode_e[i] = 0; m_data_e[i] = 0; m_end[i] = -1;
  endtask

  task automatic model_check(input int i, input int k);
    logic [N-1:0] eg, ecs, erv;
    if (m_in[i] != 0 && m_end[i] >= 0 && k >= m_free[i]) m_in[i] = 0;
    eg  = '0;
    ecs = '1;
    erv = '0;
    if (m_in[i] != 0) begin
      if (k == m_g[i]) eg[m_own[i]] = 1'b1;
      if (k >= m_g[i] && (m_end[i] < 0 || k <= m_end[i])) ecs[m_own[i]] = 1'b0;
      if (m_end[i] >= 0 && k == m_rsp[i]) erv[m_own[i]] = 1'b1;
    end
    chk("gnt",       i, k, 32'(gnt[i]),       32'(eg));
    chk("m_start",   i, k, 32'(m_start[i]),   32'((m_in[i] != 0 && k == m_s[i]) ? 1 : 0));
    chk("cs_n",      i, k, 32'(cs_n[i]),      32'(ecs));
    chk("rsp_valid", i, k, 32'(rsp_valid[i]), 32'(erv));
    chk("m_mode",    i, k, 32'(m_mode[i]),    32'(m_mode_e[i]));
    chk("m_tx_data", i, k, 32'(m_tx_data[i]), 32'(m_data_e[i]));
    if (erv != 0) begin
      chk("rsp_data", i, k, 32'(rsp_data[i]), 32'(m_rx_e[i]));
      chk("rsp_err",  i, k, 32'(rsp_err[i]),  32'(m_err_e[i]));
    end
  endtask

  task automatic model_update(input int i, input int k);
    int p;
    if (rst) begin
      model_reset(i);
      return;
    end
    if (m_in[i] == 0) begin
      p = rr_pick(req[i], m_last[i]);
      if (p >= 0) begin
        m_in[i] = 1; m_g[i] = k + 1; m_s[i] = k + 2; m_end[i] = -1;
        m_own[i] = p; m_last[i] = p;
        m_mode_e[i] = int'(req_mode[i][2*p +: 2]);
        m_data_e[i] = int'(req_data[i][DW*p +: DW]);
      end
    end else if (m_end[i] < 0 && k > m_s[i]) begin
      if (m_done[i]) begin
        m_end[i] = k; m_rx_e[i] = int'(m_rx_data[i]); m_err_e[i] = 0;
      end else if (k == m_s[i] + TO) begin
        m_end[i] = k; m_rx_e[i] = 0; m_err_e[i] = 1;
      end
      if (m_end[i] >= 0) begin
        m_rsp[i]  = m_end[i] + 1;
        m_free[i] = m_end[i] + 1 + gap_len(i);
      end
    end
  endtask

  // Stimulus: client request patterns and a behavioural SPI engine per instance.
  int   done_at[2];
  logic [DW-1:0] rx_nxt[2];
  bit   single_pend[2];
  bit   rst_done;

  task automatic drive(input int k);
    bit spurious, no_done, wait0;
    spurious = (k >= 360 && k < 2000);
    no_done  = (k >= 260 && k < 360);
    wait0    = (m_in[0] != 0 && m_end[0] < 0 && k > m_s[0]);
    rst = (k < 3);
    if (k >= 370 && k < 400 && !rst_done && wait0) begin
      rst = 1'b1;
      rst_done = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_start[i]) begin
        if (k < 60)        begin done_at[i] = k + 4; rx_nxt[i] = 8'h3C; end
        else if (no_done)  done_at[i] = -1;
        else if (k < 260)  begin done_at[i] = k + 1 + $urandom_range(0, 10); rx_nxt[i] = 8'($urandom); end
        else if (k < 400)  begin done_at[i] = k + 12; rx_nxt[i] = 8'($urandom); end
        else               begin done_at[i] = k + 1 + $urandom_range(0, 20); rx_nxt[i] = 8'($urandom); end
      end
      m_done[i]    = (k == done_at[i]) || (spurious && ($urandom_range(0, 15) == 0));
      m_rx_data[i] = (k == done_at[i]) ? rx_nxt[i] : 8'($urandom);

      for (int c = 0; c < N; c++) begin
        req_mode[i][2*c +: 2]  = 2'($urandom);
        req_data[i][DW*c +: DW] = 8'($urandom);
      end
      if (k == 5) single_pend[i] = 1'b1;
      if (k < 60) begin
        if (gnt[i][2]) single_pend[i] = 1'b0;
        req[i] = single_pend[i] ? 4'b0100 : 4'b0000;
        req_mode[i][5:4]   = 2'd3;
        req_data[i][23:16] = 8'hA5;
      end else if (k < 260) begin
        req[i] = 4'b1111;
      end else if (k >= 2000) begin
        req[i] = 4'b1010;
      end else begin
        for (int c = 0; c < N; c++) begin
          if (req[i][c] && gnt[i][c])  req[i][c] = ($urandom_range(0, 1) == 0);
          else if (req[i][c])          req[i][c] = ($urandom_range(0, 31) != 0);
          else                         req[i][c] = ($urandom_range(0, 5) == 0);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0; req_mode = '0; req_data = '0;
    m_done = '0; m_rx_data = '0;
    rst_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      model_reset(i);
      done_at[i] = -1;
      rx_nxt[i] = '0;
      single_pend[i] = 1'b0;
    end
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) model_check(i, k);
      drive(k);
      for (int i = 0; i < 2; i++) model_update(i, k);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
